f1_start_sequencer: RTL and testbench

- Top-level sequencer for the F1 starting-light game. It lights the ten-lamp gantry one lamp per step and holds all lamps for a random delay taken from the LFSR. It then extinguishes the lamps and measures the player's reaction time in milliseconds.
- Detects jump starts (button pressed before lights-out).
- Drives the LFSR enable and the delay-start strobe. Its results feed the 7-segment display logic.

---
 rtl/f1_start_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_f1_start_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_sequencer.sv
// F1 starting-light sequencer: lights the gantry lamp by lamp, holds all lamps
// for a random delay, then measures the player's reaction time and flags
// jump starts.
module f1_start_sequencer #(
    parameter int NUM_LIGHTS    = 10,
    parameter int LIGHT_STEP_MS = 500,
    parameter int MIN_DELAY_MS  = 200,
    parameter int RAND_W        = 11,
    parameter int REACT_MAX     = 9999
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              tick_ms,
    input  logic              trigger,
    input  logic              react_btn,
    input  logic [RAND_W-1:0] lfsr_val,
    output logic              en_lfsr,
    output logic              start_delay,
    output logic [9:0]        ledr,
    output logic [13:0]       react_ms,
    output logic              react_valid,
    output logic              jump_start,
    output logic              busy
);

    // Delay counter holds MIN_DELAY_MS plus the largest LFSR sample without wrapping.
    localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_W));
    localparam int SC_W  = $clog2(LIGHT_STEP_MS) + 1;
    localparam logic [10:0] ALL_ON_W = (11'd1 << NUM_LIGHTS) - 11'd1;
    localparam logic [9:0]  ALL_ON   = ALL_ON_W[9:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LIGHTS = 3'd1,
        S_DELAY  = 3'd2,
        S_REACT  = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             trigger_q, btn_q;
    logic [3:0]       light_idx_q, light_idx_d;
    logic [SC_W-1:0]  step_cnt_q, step_cnt_d;
    logic [DLY_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [13:0]      react_cnt_q, react_cnt_d;
    logic             blink_q, blink_d;
    logic [9:0]       ledr_q, ledr_d;
    logic [13:0]      react_ms_q, react_ms_d;
    logic             react_valid_q, react_valid_d;
    logic             jump_start_q, jump_start_d;
    logic             start_delay_q, start_delay_d;
    logic             trg_rise, btn_rise;

    // Thermometer code: the lowest n lamps lit.
    function automatic logic [9:0] therm(input logic [3:0] n);
        logic [9:0] t;
        for (int i = 0; i < 10; i++) begin
            t[i] = (4'(i) < n);
        end
        return t;
    endfunction

    assign trg_rise = trigger & ~trigger_q;
    assign btn_rise = react_btn & ~btn_q;

    // State and counter transitions; the registered outputs are derived from the next state.
    always_comb begin
        state_d       = state_q;
        light_idx_d   = light_idx_q;
        step_cnt_d    = step_cnt_q;
        delay_cnt_d   = delay_cnt_q;
        react_cnt_d   = react_cnt_q;
        blink_d       = blink_q;
        react_ms_d    = react_ms_q;
        react_valid_d = react_valid_q;
        jump_start_d  = jump_start_q;
        start_delay_d = 1'b0;
        ledr_d        = '0;

        case (state_q)
            S_IDLE: begin
                if (trg_rise) begin
                    state_d       = S_LIGHTS;
                    light_idx_d   = 4'd1;
                    step_cnt_d    = '0;
                    react_valid_d = 1'b0;
                    jump_start_d  = 1'b0;
                end
            end
            S_LIGHTS: begin
                // A button edge beats a same-cycle lamp step or lights-out.
                if (btn_rise) begin
                    state_d = S_FAULT;
                end else if (tick_ms) begin
                    if (step_cnt_q == SC_W'(LIGHT_STEP_MS - 1)) begin
                        step_cnt_d = '0;
                        if (light_idx_q < 4'(NUM_LIGHTS)) begin
                            light_idx_d = light_idx_q + 4'd1;
                        end else begin
                            state_d     = S_DELAY;
                            delay_cnt_d = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_val);
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + SC_W'(1);
                    end
                end
            end
            S_DELAY: begin
                if (btn_rise) begin
                    state_d = S_FAULT;
                end else if (tick_ms) begin
                    if (delay_cnt_q <= DLY_W'(1)) begin
                        state_d     = S_REACT;
                        react_cnt_d = '0;
                    end else begin
                        delay_cnt_d = delay_cnt_q - DLY_W'(1);
                    end
                end
            end
            S_REACT: begin
                // Button reports the count before any same-cycle tick.
                if (btn_rise) begin
                    state_d       = S_DONE;
                    react_ms_d    = react_cnt_q;
                    react_valid_d = 1'b1;
                end else if (tick_ms) begin
                    if (react_cnt_q >= 14'(REACT_MAX - 1)) begin
                        state_d       = S_DONE;
                        react_cnt_d   = 14'(REACT_MAX);
                        react_ms_d    = 14'(REACT_MAX);
                        react_valid_d = 1'b1;
                    end else begin
                        react_cnt_d = react_cnt_q + 14'd1;
                    end
                end
            end
            S_DONE: begin
                if (trg_rise) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                if (trg_rise) begin
                    state_d = S_IDLE;
                end else if (tick_ms) begin
                    if (step_cnt_q == SC_W'(LIGHT_STEP_MS - 1)) begin
                        step_cnt_d = '0;
                        blink_d    = ~blink_q;
                    end else begin
                        step_cnt_d = step_cnt_q + SC_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Common jump-start entry: blink phase restarts lit.
        if (state_d == S_FAULT && state_q != S_FAULT) begin
            jump_start_d  = 1'b1;
            react_valid_d = 1'b0;
            step_cnt_d    = '0;
            blink_d       = 1'b1;
        end

        start_delay_d = (state_q == S_LIGHTS) && (state_d == S_DELAY);

        case (state_d)
            S_LIGHTS: ledr_d = therm(light_idx_d);
            S_DELAY:  ledr_d = ALL_ON;
            S_FAULT:  ledr_d = blink_d ? ALL_ON : 10'd0;
            default:  ledr_d = 10'd0;
        endcase
    end

    // State, counters, edge detectors and registered outputs.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            trigger_q     <= 1'b0;
            btn_q         <= 1'b0;
            light_idx_q   <= '0;
            step_cnt_q    <= '0;
            delay_cnt_q   <= '0;
            react_cnt_q   <= '0;
            blink_q       <= 1'b0;
            ledr_q        <= '0;
            react_ms_q    <= '0;
            react_valid_q <= 1'b0;
            jump_start_q  <= 1'b0;
            start_delay_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            trigger_q     <= trigger;
            btn_q         <= react_btn;
            light_idx_q   <= light_idx_d;
            step_cnt_q    <= step_cnt_d;
            delay_cnt_q   <= delay_cnt_d;
            react_cnt_q   <= react_cnt_d;
            blink_q       <= blink_d;
            ledr_q        <= ledr_d;
            react_ms_q    <= react_ms_d;
            react_valid_q <= react_valid_d;
            jump_start_q  <= jump_start_d;
            start_delay_q <= start_delay_d;
        end
    end

    assign en_lfsr     = (state_q == S_IDLE) || (state_q == S_LIGHTS);
    assign busy        = (state_q == S_LIGHTS) || (state_q == S_DELAY) || (state_q == S_REACT);
    assign ledr        = ledr_q;
    assign react_ms    = react_ms_q;
    assign react_valid = react_valid_q;
    assign jump_start  = jump_start_q;
    assign start_delay = start_delay_q;

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Bench for f1_start_sequencer: directed scenarios plus random stimulus,
// checked every cycle against a tick-counting behavioural model.
module tb_f1_start_sequencer;

    localparam int N    = 10;
    localparam int STEP = 4;
    localparam int MIND = 2;
    localparam int RW   = 11;
    localparam int RMAX = 50;
    localparam logic [9:0] ALL = 10'h3FF;

    logic          sysclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick_ms = 1'b0;
    logic          trigger = 1'b0;
    logic          react_btn = 1'b0;
    logic [RW-1:0] lfsr_val = '0;
    logic          en_lfsr, start_delay, react_valid, jump_start, busy;
    logic [9:0]    ledr;
    logic [13:0]   react_ms;

    f1_start_sequencer #(
        .NUM_LIGHTS(N), .LIGHT_STEP_MS(STEP), .MIN_DELAY_MS(MIND),
        .RAND_W(RW), .REACT_MAX(RMAX)
    ) dut (
        .sysclk(sysclk), .rst_n(rst_n), .tick_ms(tick_ms), .trigger(trigger),
        .react_btn(react_btn), .lfsr_val(lfsr_val), .en_lfsr(en_lfsr),
        .start_delay(start_delay), .ledr(ledr), .react_ms(react_ms),
        .react_valid(react_valid), .jump_start(jump_start), .busy(busy)
    );

    always #5 sysclk = ~sysclk;

    int vectors = 0;
    int miscompares = 0;

    typedef enum int {P_IDLE, P_LIGHTS, P_DELAY, P_REACT, P_DONE, P_FAULT} phase_t;
    phase_t m_phase;
    int     m_ticks;
    int     m_delay;
    logic   m_pt, m_pb;
    int     m_rms;
    logic   m_valid, m_jump, m_sd;
    int     n_sd, n_all;

    function automatic logic [9:0] therm(input int n);
        return 10'((1 << n) - 1);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_ticks = 0; m_delay = 0;
        m_pt = 1'b0; m_pb = 1'b0;
        m_rms = 0; m_valid = 1'b0; m_jump = 1'b0; m_sd = 1'b0;
    endtask

    task automatic go_fault();
        m_phase = P_FAULT; m_ticks = 0; m_jump = 1'b1; m_valid = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic trg, br;
        if (!rst_n) begin
            model_reset();
            return;
        end
        trg  = trigger & ~m_pt;
        br   = react_btn & ~m_pb;
        m_pt = trigger;
        m_pb = react_btn;
        m_sd = 1'b0;
        case (m_phase)
            P_IDLE: if (trg) begin
                m_phase = P_LIGHTS; m_ticks = 0; m_valid = 1'b0; m_jump = 1'b0;
            end
            P_LIGHTS: if (br) go_fault();
                else if (tick_ms) begin
                    m_ticks++;
                    if (m_ticks == N * STEP) begin
                        m_phase = P_DELAY; m_ticks = 0; m_delay = MIND + int'(lfsr_val); m_sd = 1'b1;
                    end
                end
            P_DELAY: if (br) go_fault();
                else if (tick_ms) begin
                    m_ticks++;
                    if (m_ticks == m_delay) begin
                        m_phase = P_REACT; m_ticks = 0;
                    end
                end
            P_REACT: if (br) begin
                    m_phase = P_DONE; m_rms = m_ticks; m_valid = 1'b1;
                end else if (tick_ms) begin
                    m_ticks++;
                    if (m_ticks == RMAX) begin
                        m_phase = P_DONE; m_rms = RMAX; m_valid = 1'b1;
                    end
                end
            P_DONE: if (trg) m_phase = P_IDLE;
            P_FAULT: if (trg) m_phase = P_IDLE;
                else if (tick_ms) m_ticks++;
            default: m_phase = P_IDLE;
        endcase
    endtask

    function automatic logic [9:0] exp_ledr();
        int lamps;
        case (m_phase)
            P_LIGHTS: begin
                lamps = m_ticks / STEP + 1;
                if (lamps > N) lamps = N;
                return therm(lamps);
            end
            P_DELAY: return therm(N);
            P_FAULT: return ((m_ticks / STEP) % 2 == 0) ? therm(N) : 10'd0;
            default: return 10'd0;
        endcase
    endfunction

    task automatic compare();
        logic       bad;
        logic [9:0] el;
        logic       eb, ee;
        bad = 1'b0;
        el  = exp_ledr();
        eb  = (m_phase == P_LIGHTS) || (m_phase == P_DELAY) || (m_phase == P_REACT);
        ee  = (m_phase == P_IDLE) || (m_phase == P_LIGHTS);
        vectors++;
        if (ledr !== el) begin
            $display("FAIL ledr t=%0t got %h want %h", $time, ledr, el); bad = 1'b1;
        end
        if (react_ms !== 14'(m_rms)) begin
            $display("FAIL react_ms t=%0t got %0d want %0d", $time, react_ms, m_rms); bad = 1'b1;
        end
        if (react_valid !== m_valid) begin
            $display("FAIL react_valid t=%0t got %b want %b", $time, react_valid, m_valid); bad = 1'b1;
        end
        if (jump_start !== m_jump) begin
            $display("FAIL jump_start t=%0t got %b want %b", $time, jump_start, m_jump); bad = 1'b1;
        end
        if (start_delay !== m_sd) begin
            $display("FAIL start_delay t=%0t got %b want %b", $time, start_delay, m_sd); bad = 1'b1;
        end
        if (busy !== eb) begin
            $display("FAIL busy t=%0t got %b want %b", $time, busy, eb); bad = 1'b1;
        end
        if (en_lfsr !== ee) begin
            $display("FAIL en_lfsr t=%0t got %b want %b", $time, en_lfsr, ee); bad = 1'b1;
        end
        if (bad) miscompares++;
        if (start_delay === 1'b1) n_sd++;
        if (ledr === ALL && busy === 1'b1) n_all++;
    endtask

    task automatic check_lit(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            $display("FAIL %s got %0d want %0d", name, act, want);
            miscompares++;
        end
    endtask

    task automatic cycle();
        @(posedge sysclk);
        model_step();
        #1;
        compare();
    endtask

    // Step until the model reaches a phase (and tick count, if t >= 0), bounded.
    task automatic wait_model(input phase_t p, input int t, input int limit, input string name);
        int i;
        i = 0;
        while (!(m_phase == p && (t < 0 || m_ticks == t)) && i < limit) begin
            cycle();
            i++;
        end
        if (!(m_phase == p && (t < 0 || m_ticks == t))) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_%s after %0d cycles", name, limit);
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1; cycle(); trigger = 1'b0;
    endtask

    initial begin
        model_reset();
        tick_ms = 1'b1;
        repeat (3) cycle();
        check_lit("reset_ledr", int'(ledr), 0);
        check_lit("reset_busy", int'(busy), 0);
        check_lit("reset_en_lfsr", int'(en_lfsr), 1);
        #2 rst_n = 1'b1;

        // Asynchronous reset in the middle of LIGHTS.
        pulse_trigger();
        repeat (10) cycle();
        check_lit("lights_ledr_3rd", int'(ledr), 'h007);
        #2 rst_n = 1'b0;
        #1;
        check_lit("async_rst_ledr", int'(ledr), 0);
        check_lit("async_rst_busy", int'(busy), 0);
        check_lit("async_rst_en_lfsr", int'(en_lfsr), 1);
        model_reset();
        repeat (2) cycle();
        #2 rst_n = 1'b1;
        repeat (100) cycle();
        check_lit("idle_after_rst_busy", int'(busy), 0);

        // Full sequence with a 23 ms reaction.
        lfsr_val = 11'd5;
        n_sd = 0; n_all = 0;
        pulse_trigger();
        check_lit("first_lamp", int'(ledr), 'h001);
        wait_model(P_REACT, 23, 200, "react23");
        react_btn = 1'b1; cycle(); react_btn = 1'b0; cycle();
        check_lit("react_ms_23", int'(react_ms), 23);
        check_lit("react_valid_23", int'(react_valid), 1);
        check_lit("busy_done", int'(busy), 0);
        check_lit("start_delay_pulses", n_sd, 1);
        check_lit("all_lit_cycles", n_all, 4 + 7);

        // DONE -> IDLE keeps the result.
        pulse_trigger(); cycle();
        check_lit("valid_held_idle", int'(react_valid), 1);
        check_lit("ms_held_idle", int'(react_ms), 23);

        // Jump start during the 3rd lamp.
        pulse_trigger();
        wait_model(P_LIGHTS, 9, 100, "lamp3");
        react_btn = 1'b1; cycle(); react_btn = 1'b0;
        repeat (20) cycle();
        check_lit("jump_flag", int'(jump_start), 1);
        check_lit("jump_valid", int'(react_valid), 0);
        check_lit("jump_ms_kept", int'(react_ms), 23);
        pulse_trigger(); cycle();
        check_lit("fault_exit_ledr", int'(ledr), 0);

        // Button on the exact lights-out tick is a jump start.
        pulse_trigger();
        wait_model(P_DELAY, 6, 200, "lightsout");
        react_btn = 1'b1; cycle(); react_btn = 1'b0; cycle();
        check_lit("lightsout_jump", int'(jump_start), 1);
        check_lit("lightsout_busy", int'(busy), 0);
        pulse_trigger(); cycle();

        // Timeout with no button.
        pulse_trigger();
        wait_model(P_DONE, -1, 300, "timeout");
        cycle();
        check_lit("timeout_ms", int'(react_ms), RMAX);
        check_lit("timeout_valid", int'(react_valid), 1);

        // Trigger held high starts only one sequence.
        pulse_trigger(); cycle();
        n_sd = 0;
        lfsr_val = RW'($urandom_range(0, 15));
        trigger = 1'b1;
        repeat (250) cycle();
        trigger = 1'b0;
        check_lit("held_trigger_runs", n_sd, 1);

        // Largest LFSR sample, with trigger toggling during the run.
        pulse_trigger(); cycle();
        lfsr_val = 11'h7FF;
        n_all = 0;
        pulse_trigger();
        for (int i = 0; i < 3000 && m_phase != P_REACT; i++) begin
            trigger = ~trigger;
            cycle();
        end
        trigger = 1'b0;
        check_lit("max_delay_all_lit", n_all, 4 + MIND + 2047);
        wait_model(P_DONE, -1, 100, "max_done");

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            tick_ms   = 1'($urandom_range(0, 1));
            trigger   = ($urandom_range(0, 19) == 0);
            react_btn = ($urandom_range(0, 59) == 0) ? ~react_btn : react_btn;
            lfsr_val  = ($urandom_range(0, 9) == 0) ? RW'($urandom) : RW'($urandom_range(0, 20));
            rst_n     = ($urandom_range(0, 999) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
